// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : Single-ported 32-bit word data memory behind a valid/ready
//               request channel and a valid/ready response channel. One
//               request is outstanding at a time; the response appears a
//               fixed LATENCY cycles after acceptance and is held until the
//               initiator takes it.
//
// Parameters  : DEPTH   - number of 32-bit words (power of two, >= 4)
//               LATENCY - cycles from acceptance to resp_valid (>= 1)
//
// Ports       : clk         - clock, rising edge
//               rst_b       - asynchronous reset, active high
//               req_valid   - request presented
//               req_ready   - request can be accepted (IDLE only)
//               req_addr    - byte address
//               req_we      - 1 = store, 0 = load
//               req_wdata   - store data, little-endian byte lanes
//               req_be      - store byte enables (ignored for loads)
//               resp_valid  - response presented (RESP only)
//               resp_ready  - initiator accepts the response
//               resp_rdata  - load data; 0 for stores and errors
//               resp_err    - request rejected (qualified by resp_valid)
//
// Build option: DMEM_ERR_CHECK_EN - when defined, misaligned or out-of-range
//               requests are answered with resp_err=1 and no access. When
//               undefined, addr[1:0] is ignored, the word index wraps modulo
//               DEPTH and resp_err is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_CW-1:0] c_CNT_LOAD = c_CW'(LATENCY - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_addr;
    logic            r_we;
    logic [31:0]     r_wdata;
    logic [3:0]      r_be;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic [1:0]      w_state_nxt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_accept;
    logic            w_enter_resp;

    logic [31:0]     w_acc_addr;
    logic            w_acc_we;
    logic [31:0]     w_acc_wdata;
    logic [3:0]      w_acc_be;
    logic [c_AW-1:0] w_idx;
    logic            w_err;

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // Held low while reset is asserted so nothing is offered
                // until the first edge after release.
                req_ready = ~rst_b;
                if (req_valid) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = c_CNT_LOAD;
                    if (LATENCY == 1) begin
                        w_state_nxt  = c_ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                // The counter reaches 0 on the edge that enters RESP, which
                // places resp_valid in the LATENCY-th cycle after acceptance
                // and gives an acceptance spacing of LATENCY+1.
                w_cnt_nxt = r_cnt - c_CNT_ONE;
                if (r_cnt <= c_CNT_ONE) begin
                    w_state_nxt  = c_ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            c_ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge itself, so the
    // operands come straight from the request port rather than the latches.
    assign w_acc_addr  = (r_state == c_ST_IDLE) ? req_addr  : r_addr;
    assign w_acc_we    = (r_state == c_ST_IDLE) ? req_we    : r_we;
    assign w_acc_wdata = (r_state == c_ST_IDLE) ? req_wdata : r_wdata;
    assign w_acc_be    = (r_state == c_ST_IDLE) ? req_be    : r_be;
    assign w_idx       = w_acc_addr[c_AW+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign w_err = (w_acc_addr[1:0] != 2'b00) ||
                   (w_acc_addr[31:2] >= 30'(DEPTH));
`else
    logic [31-c_AW:0] w_unused_addr_bits;
    assign w_unused_addr_bits = {w_acc_addr[31:c_AW+2], w_acc_addr[1:0]};
    assign w_err = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State, request latches and response registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_we;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_acc_we || w_err) ? 32'h0 : r_mem[w_idx];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage array: never reset; a store is committed only on the edge that
    // enters RESP, so a reset during WAIT drops it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_acc_we && !w_err && !rst_b) begin
            for (int k = 0; k < 4; k++) begin
                if (w_acc_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_acc_wdata[8*k +: 8];
                end
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_resp
// Description : Self-checking bench for data_mem_resp. A LATENCY=2 instance
//               runs a table of load/store vectors plus backpressure and
//               reset sequences; a LATENCY=1 instance runs a back-to-back
//               sequence. Expectations follow DMEM_ERR_CHECK_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    logic        clk;
    logic        rst_b;

    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        l1_req_valid, l1_req_ready, l1_req_we, l1_resp_valid;
    logic        l1_resp_ready, l1_resp_err;
    logic [31:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;
    logic [3:0]  l1_req_be;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_resp #(.DEPTH(1024), .LATENCY(2)) u_dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_we     (req_we),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    data_mem_resp #(.DEPTH(1024), .LATENCY(1)) u_dut_l1 (
        .clk        (clk),
        .rst_b      (rst_b),
        .req_valid  (l1_req_valid),
        .req_ready  (l1_req_ready),
        .req_addr   (l1_req_addr),
        .req_we     (l1_req_we),
        .req_wdata  (l1_req_wdata),
        .req_be     (l1_req_be),
        .resp_valid (l1_resp_valid),
        .resp_ready (l1_resp_ready),
        .resp_rdata (l1_resp_rdata),
        .resp_err   (l1_resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1. Issues one request with resp_ready=1 and checks
    // latency, response contents and completion.
    task automatic run_req(input string name, input vec_t v);
        int cyc;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({name, " req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_be     = v.be;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        // Scramble request inputs: they must be ignored outside IDLE.
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_addr  = 32'h0000_0004;
        req_wdata = 32'h5555_5555;
        req_be    = 4'hF;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check({name, " latency"}, 32'(cyc), 32'd2);
        check({name, " rdata"}, resp_rdata, v.exp_rdata);
        check({name, " err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
        @(posedge clk); #1;
        check({name, " done"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic run(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v = '{we, addr, wdata, be, exp_rdata, exp_err};
        run_req(name, v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        int          cyc;

        rst_b = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b1;
        l1_req_valid = 1'b0; l1_req_we = 1'b0; l1_req_addr = '0; l1_req_wdata = '0;
        l1_req_be = '0; l1_resp_ready = 1'b1;

        // ---------------- vector table ----------------
        vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hF, 32'hDEADBEAA, 1'b0});
        vecs.push_back('{1'b1, 32'h14,   32'h12345678, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b1, 32'h14,   32'hAABBCCDD, 4'hA, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h14,   32'h0,        4'h0, 32'hAA34CC78, 1'b0});
        vecs.push_back('{1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
        vecs.push_back('{1'b1, 32'hFFC,  32'h5A5A5A5A, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
        vecs.push_back('{1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0,        1'b0});
`ifdef DMEM_ERR_CHECK_EN
        vecs.push_back('{1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b1, 32'h1000, 32'h99999999, 4'hF, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'h01020304, 1'b0});
`else
        vecs.push_back('{1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0});
        vecs.push_back('{1'b1, 32'h1000, 32'h99999999, 4'hF, 32'h0,        1'b0});
        vecs.push_back('{1'b0, 32'h0,    32'h0,        4'h0, 32'h99999999, 1'b0});
`endif

        // ---------------- reset state ----------------
        #12;
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset resp_err", {31'b0, resp_err}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'd0);
        check("reset req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        check("post-reset req_ready", {31'b0, req_ready}, 32'd1);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            run_req($sformatf("vec%0d", i), vecs[i]);
        end

        // ---------------- backpressure ----------------
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_be = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("bp latency", 32'(cyc), 32'd2);
        held = resp_rdata;
        check("bp rdata", held, 32'hAA34CC78);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp hold valid %0d", i), {31'b0, resp_valid}, 32'd1);
            check($sformatf("bp hold rdata %0d", i), resp_rdata, held);
            check($sformatf("bp req_ready %0d", i), {31'b0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp complete valid", {31'b0, resp_valid}, 32'd0);
        check("bp complete req_ready", {31'b0, req_ready}, 32'd1);

        // ---------------- reset during WAIT drops the store ----------------
        run("rst pre-store", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
        req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_b = 1'b1;
        #1;
        check("rst wait valid", {31'b0, resp_valid}, 32'd0);
        check("rst wait err", {31'b0, resp_err}, 32'd0);
        check("rst wait rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(posedge clk); #1;
        run("rst load 0x20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h11223344, 1'b0);

        // ---------------- reset during RESP clears outputs immediately ------
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check("rst resp pre rdata", resp_rdata, 32'hDEADBEAA);
        rst_b = 1'b1;
        #1;
        check("rst resp valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("rst resp req_ready", {31'b0, req_ready}, 32'd1);

        // ---------------- LATENCY=1, back-to-back ----------------
        l1_req_valid = 1'b1; l1_req_we = 1'b1; l1_req_addr = 32'h8;
        l1_req_wdata = 32'h0BADF00D; l1_req_be = 4'hF; l1_resp_ready = 1'b1;
        check("l1 ready before", {31'b0, l1_req_ready}, 32'd1);
        @(posedge clk); #1;
        check("l1 st valid", {31'b0, l1_resp_valid}, 32'd1);
        check("l1 st rdata", l1_resp_rdata, 32'd0);
        check("l1 st req_ready", {31'b0, l1_req_ready}, 32'd0);
        l1_req_we = 1'b0;
        @(posedge clk); #1;
        check("l1 gap valid", {31'b0, l1_resp_valid}, 32'd0);
        check("l1 gap req_ready", {31'b0, l1_req_ready}, 32'd1);
        @(posedge clk); #1;
        check("l1 ld valid", {31'b0, l1_resp_valid}, 32'd1);
        check("l1 ld rdata", l1_resp_rdata, 32'h0BADF00D);
        check("l1 ld err", {31'b0, l1_resp_err}, 32'd0);
        l1_req_valid = 1'b0;
        @(posedge clk); #1;
        check("l1 done valid", {31'b0, l1_resp_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, the number of 32-bit words stored; it must be a power of two and at least 4.
REQ-002 SHALL have parameter LATENCY, default 2, the number of cycles from request acceptance to resp_valid; it must be at least 1.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_b, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: the initiator presents a memory request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 SHALL have port req_addr, input, 32 bits: the byte address.
REQ-008 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data; byte lane k is bits [8k+7:8k], and lane 0 is the lowest byte address (little-endian).
REQ-010 SHALL have port req_be, input, 4 bits: the store byte enables, one per lane; ignored for loads.
REQ-011 SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-012 SHALL have port resp_ready, input, 1 bit: the initiator accepts the response.
REQ-013 SHALL have port resp_rdata, output, 32 bits: load data, same lane order as req_wdata; 0 for stores and errors.
REQ-014 SHALL have port resp_err, output, 1 bit: the request was rejected; qualified by resp_valid.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE and resp_valid=1 only in RESP.
REQ-017 SHALL accept a request (req_valid & req_ready at a rising edge) by latching addr, we, wdata and be, loading the counter with LATENCY-1, and entering WAIT; if LATENCY=1 it enters RESP directly.
REQ-018 SHALL in WAIT decrement the counter each cycle and enter RESP on the edge at which the counter equals 0, so resp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-019 SHALL perform the memory access on the edge entering RESP:
- store: write only the enabled lanes of word addr[31:2]; resp_rdata=0.
- load: resp_rdata = that word.
REQ-020 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1 at an edge, then return to IDLE.
REQ-021 SHALL NOT accept a new request in the cycle a response completes (req_ready=0 during RESP), so at most one request is outstanding; minimum spacing between acceptances is LATENCY+1 cycles.
REQ-022 SHALL make a load following a store to the same word return the stored data, because requests are strictly serialized.
REQ-023 SHALL treat a store with req_be=4'b0000 as a successful no-op write.
REQ-024 SHALL ignore changes on request inputs while not in IDLE.

Reset
REQ-025 SHALL on rst_b=1, immediately and asynchronously, force IDLE, counter=0, resp_valid=0, resp_err=0 and resp_rdata=0; req_ready=1 from the first edge after rst_b falls.
REQ-026 SHALL on reset during WAIT or RESP drop the pending request; a store not yet written is never written.
REQ-027 SHALL leave memory array contents unchanged by reset.

Configuration
REQ-028 SHALL use macro DMEM_ERR_CHECK_EN.
REQ-029 SHALL when DMEM_ERR_CHECK_EN is defined, set resp_err=1 and perform no access (resp_rdata=0, no write) for a request with req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH; latency and handshake are unchanged.
REQ-030 SHALL when DMEM_ERR_CHECK_EN is not defined, ignore req_addr[1:0], use the word index req_addr[31:2] modulo DEPTH, and tie resp_err to 0.

Verification
REQ-031 SHALL verify (LATENCY=2) store addr=0x10, wdata=0xDEADBEEF, be=4'hF, resp_ready=1 -> resp_valid exactly 2 cycles after acceptance, resp_err=0; a following load at 0x10 -> resp_rdata=0xDEADBEEF.
REQ-032 SHALL verify store 0x10 with wdata=0x000000AA and be=4'b0001 over 0xDEADBEEF -> a load at 0x10 returns 0xDEADBEAA.
REQ-033 SHALL verify backpressure: resp_ready=0 for 5 cycles -> resp_valid and resp_rdata held constant and req_ready=0; the response completes on the edge where resp_ready=1, and req_ready=1 the next cycle.
REQ-034 SHALL verify with DMEM_ERR_CHECK_EN: load 0x13 -> resp_err=1, rdata=0; store 0x00001000 with DEPTH=1024 -> resp_err=1 and word 0 unchanged. Without the macro: a load at 0x13 returns word 0x10.
REQ-035 SHALL verify rst_b asserted one cycle after accepting a store to 0x20 -> outputs at reset values immediately; a later load at 0x20 returns the pre-store value.
REQ-036 SHALL verify LATENCY=1: resp_valid asserts on the cycle right after the acceptance edge; back-to-back requests are accepted every 2 cycles.
